// File: rtl/multi_key_debounce.sv
// Multi-channel key debouncer: 2-flop sync, per-key stability counter, registered event pulses.
// Define LONG_PRESS_EN to add a per-key hold counter that drives long_pulse.
module multi_key_debounce #(
  parameter int   NUM_KEYS        = 4,
  parameter int   DEBOUNCE_CYCLES = 1000000,
  parameter int   LONG_CYCLES     = 50000000,
  parameter logic PRESS_LEVEL     = 1'b0
) (
  input  logic                key_clk,
  input  logic                key_rst_n,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_value,
  output logic [NUM_KEYS-1:0] key_flag,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse
);

  localparam int                 CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]      CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_KEYS-1:0] RELEASED = {NUM_KEYS{~PRESS_LEVEL}};

  if (NUM_KEYS < 1 || NUM_KEYS > 32 || DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
    $error("multi_key_debounce: parameter out of range");
  end

  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  logic [NUM_KEYS-1:0] value_q, value_d;
  logic [NUM_KEYS-1:0] flag_q, flag_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [CW-1:0]       cnt_q [NUM_KEYS];
  logic [CW-1:0]       cnt_d [NUM_KEYS];

  always_comb begin
    // NOTE: every signal gets a default before the loop so no path leaves it unassigned (no latches).
    value_d   = value_q;
    flag_d    = '0;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != value_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          value_d[i]   = sync2_q[i];
          flag_d[i]    = 1'b1;
          press_d[i]   = (sync2_q[i] == PRESS_LEVEL);
          release_d[i] = (sync2_q[i] != PRESS_LEVEL);
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge key_clk or negedge key_rst_n) begin
    if (!key_rst_n) begin
      sync1_q   <= RELEASED;
      sync2_q   <= RELEASED;
      value_q   <= RELEASED;
      flag_q    <= '0;
      press_q   <= '0;
      release_q <= '0;
      // NOTE: the counters are plain flops, not a RAM, so they are cleared here to discard partial counts.
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values (sync chain stays two deep).
      sync1_q   <= key;
      sync2_q   <= sync1_q;
      value_q   <= value_d;
      flag_q    <= flag_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign key_value     = value_q;
  assign key_flag      = flag_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

`ifdef LONG_PRESS_EN
  localparam int            HW        = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYCLES);

  logic [HW-1:0]       hold_q [NUM_KEYS];
  logic [HW-1:0]       hold_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] long_q, long_d;

  // Parking the hold count one past the trigger value gives one long pulse per press.
  always_comb begin
    long_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      hold_d[i] = '0;
      if (value_q[i] == PRESS_LEVEL) begin
        hold_d[i] = (hold_q[i] == HOLD_SAT) ? hold_q[i] : hold_q[i] + HW'(1);
        long_d[i] = (hold_q[i] == HOLD_LAST);
      end
    end
  end

  always_ff @(posedge key_clk or negedge key_rst_n) begin
    if (!key_rst_n) begin
      long_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) hold_q[i] <= '0;
    end else begin
      long_q <= long_d;
      for (int i = 0; i < NUM_KEYS; i++) hold_q[i] <= hold_d[i];
    end
  end

  assign long_pulse = long_q;
`else
  assign long_pulse = '0;
`endif

endmodule

// File: doc/multi_key_debounce.md
MULTI_KEY_DEBOUNCE -- requirements
Module: multi_key_debounce

Interface
REQ-001 Parameters SHALL be:
- NUM_KEYS, 4, number of independent key channels (1..32).
- DEBOUNCE_CYCLES, 1000000, stable cycles required before a level is accepted (20 ms at 50 MHz); minimum 2.
- LONG_CYCLES, 50000000, pressed cycles before a long-press event (1 s at 50 MHz); used only with LONG_PRESS_EN.
- PRESS_LEVEL, 0, raw key level meaning "pressed".
REQ-002 Ports SHALL be:
- key_clk  in  1  system clock.
- key_rst_n  in  1  reset.
- key  in  NUM_KEYS  raw asynchronous key inputs.
- key_value  out  NUM_KEYS  debounced level per channel.
- key_flag  out  NUM_KEYS  one-cycle pulse on any accepted level change.
- press_pulse  out  NUM_KEYS  one-cycle pulse when the accepted level becomes PRESS_LEVEL.
- release_pulse  out  NUM_KEYS  one-cycle pulse when the accepted level leaves PRESS_LEVEL.
- long_pulse  out  NUM_KEYS  one-cycle long-press pulse.
REQ-003 The block SHALL use one clock, key_clk; reset key_rst_n SHALL be asynchronous and active-low.

Function
REQ-004 Each key bit SHALL pass through a two-flop synchronizer, giving the synchronized value s[i].
REQ-005 Each channel SHALL have a counter of width $clog2(DEBOUNCE_CYCLES).
- When s[i]==key_value[i], the counter SHALL clear to 0.
- Otherwise the counter SHALL increment.
REQ-006 When s[i]!=key_value[i] and the counter equals DEBOUNCE_CYCLES-1:
- key_value[i] SHALL take s[i] on that edge.
- key_flag[i] SHALL assert for exactly one cycle.
- Exactly one of press_pulse[i] / release_pulse[i] SHALL assert for exactly one cycle.
- The counter SHALL clear.
REQ-007 Latency SHALL be 2+DEBOUNCE_CYCLES cycles, measured from the raw edge to the key_value update, for an input that is clean from that edge.
REQ-008 Any return of s[i] to key_value[i] before acceptance SHALL restart the count from 0; glitches shorter than DEBOUNCE_CYCLES SHALL produce no event.
REQ-009 Channels SHALL be fully independent; simultaneous acceptance on several channels SHALL give simultaneous pulses.
REQ-010 Pulse outputs SHALL be registered and SHALL never stay high for two consecutive cycles.
REQ-011 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
REQ-012 While key_rst_n=0:
- The synchronizer flops and key_value SHALL be set to ~PRESS_LEVEL (released).
- All counters SHALL be 0.
- key_flag, press_pulse, release_pulse and long_pulse SHALL be 0.
REQ-013 Reset asserted mid-count SHALL discard the partial count; no pulse SHALL be emitted on reset release.
REQ-014 A key held pressed through reset release SHALL be reported as a normal press after 2+DEBOUNCE_CYCLES cycles.

Configuration
REQ-015 With macro LONG_PRESS_EN defined:
- Each channel SHALL have a hold counter that clears while key_value[i]!=PRESS_LEVEL and increments while key_value[i]==PRESS_LEVEL.
- long_pulse[i] SHALL assert for exactly one cycle when the hold counter reaches LONG_CYCLES-1.
- The hold counter SHALL then saturate, giving one long pulse per press.
- Release SHALL clear the hold counter; release_pulse SHALL still fire normally.
REQ-016 Without LONG_PRESS_EN:
- The long_pulse port SHALL exist and be driven constant 0.
- No hold-counter logic SHALL be synthesized.

Verification (DEBOUNCE_CYCLES=8, LONG_CYCLES=20, NUM_KEYS=4, PRESS_LEVEL=0)
REQ-017 Clean press: key[0] 1->0 held -> key_value[0]=0 and press_pulse[0]=key_flag[0]=1 for one cycle, 10 cycles after the edge; other channels unchanged.
REQ-018 Bounce: key[1] low 5 cycles, high 2, low held -> single press_pulse[1], 10 cycles after the final falling edge; no earlier pulse.
REQ-019 Simultaneous: key[3:0] 1111->0000 held 12 cycles, then ->1111 -> four press pulses in the same cycle, later four release pulses in the same cycle.
REQ-020 Reset mid-count: key[2]=0 for 6 cycles, then key_rst_n low 1 cycle, key held 0 -> no pulse before release; press_pulse[2] exactly 10 cycles after reset deasserts.
REQ-021 Long press (LONG_PRESS_EN): key[0] held low 60 cycles -> exactly one long_pulse[0], 20 cycles after press_pulse[0]; with macro undefined -> long_pulse stays 0000.
